conv_puncturer: RTL and testbench
=================================

Name: conv_puncturer

Overview:
- Sits directly downstream of the rate-1/2 convolutional encoder. It consumes one coded pair per accepted cycle: AB[1] is the A (G1) bit and AB[0] is the B (G2) bit.
- It deletes bits according to a selectable puncture pattern to give code rate 1/2, 2/3 or 3/4.
- Surviving bits are emitted as a serial stream through a small bit FIFO with a valid/ready handshake toward the modulator/serializer stage.

Parameters:
- DEPTH, 8, bit-FIFO depth in bits. Must be a power of two and at least 4.
- CNT_W, 16, width of the optional dropped-bit counter.

Ports:
- Clk  input  1  system clock. All state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- AB  input  2  coded pair from the encoder. AB[1] = A bit, AB[0] = B bit.
- valid_in  input  1  AB is valid this cycle.
- in_ready  output  1  puncturer can accept a pair this cycle.
- rate  input  2  00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = treated as 1/2.
- out_bit  output  1  serial coded bit at the FIFO head.
- out_valid  output  1  out_bit is valid (FIFO not empty).
- out_ready  input  1  downstream accepts out_bit this cycle.
- drop_cnt  output  CNT_W  dropped-bit count. Present only with PUNCT_CNT_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO read pointer, write pointer and count cleared to 0; phase cleared to 0; rate_q cleared to 00.
  - Outputs during and after reset: out_valid=0, out_bit=0, in_ready=1, drop_cnt=0.
  - A reset in the middle of a puncture period discards all buffered bits and the partial period.
- Accept rule:
  - A pair is accepted when valid_in && in_ready.
  - in_ready = (DEPTH - count) >= 2, registered-state based, with no combinational path from valid_in.
  - While in_ready=0 the offered pair is ignored. The upstream encoder must hold or stall it.
- Rate latch:
  - rate is sampled into rate_q only when a pair is accepted while phase==0.
  - The puncture decision for the phase-0 pair itself uses the live rate value.
  - Changes to rate in mid-period take effect at the next period start.
- Puncture patterns (A row / B row, 1 = keep). Each pair pushes A first, then B, if kept:
  - 1/2: period 1, keep A0 B0 (2 bits per pair).
  - 2/3: period 2, A=11 B=10. Output sequence A0 B0 A1 (3 bits per 2 pairs).
  - 3/4: period 3, A=110 B=101. Output sequence A0 B0 A1 B2 (4 bits per 3 pairs).
- Phase counter:
  - Range 0..period-1. Increments on each accepted pair and wraps to 0 at period-1.
  - In 1/2 mode it stays at 0.
- FIFO:
  - Per cycle, push 0, 1 or 2 bits and pop 0 or 1 bit.
  - A pop occurs when out_valid && out_ready.
  - Count update: count_next = count + pushes - pop. Push and pop in the same cycle are both legal, including when full-minus-2 and when empty.
  - Pushes go only into free slots (guaranteed by the in_ready rule). An empty FIFO never pops.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - When two bits are pushed, A goes to wr_ptr and B to wr_ptr+1 (mod DEPTH).
- Output:
  - out_bit = fifo[rd_ptr]; out_valid = (count != 0).
  - Latency: a bit pushed in cycle n is visible on out_bit/out_valid in cycle n+1 when the FIFO was empty.
  - out_bit holds its value while out_valid && !out_ready.
  - When empty, out_bit is don't-care but driven from storage with no X.

Optional Feature:
- Macro: PUNCT_CNT_EN.
- Defined:
  - drop_cnt port exists.
  - Increments by the number of bits deleted per accepted pair (0 or 1), saturating at all-ones.
  - Cleared only by reset.
- Not defined: port and counter are absent. Puncturing behaviour is identical in both builds.

Test Plan:
- Rate 1/2, out_ready=1, pairs AB=10 then 01 on consecutive cycles -> out_bit sequence 1,0,0,1. First out_valid appears one cycle after the first accept.
- Rate 2/3, pairs AB=10 then 01 -> output 1,0,0 (B1 dropped), phase back to 0. drop_cnt=1 with PUNCT_CNT_EN.
- Rate 3/4, pairs 11, 00, 01 -> output 1,1,0,1 (B1 and A2 dropped); drop_cnt=2.
- Backpressure:
  - Stimulus: out_ready=0, rate 1/2, DEPTH=8, valid_in held high with AB=11.
  - Required: exactly 4 pairs accepted, then in_ready=0 and count=8; further pairs are ignored.
  - Then release out_ready: 8 ones drained at 1 bit/cycle; in_ready returns to 1 once count<=6.
- Rate change and reset:
  - Stimulus: at rate 2/3, accept one pair (phase=1), switch rate to 3/4, accept the next pair.
  - Required: the second pair uses the 2/3 phase-1 pattern (A kept, B dropped).
  - Then assert reset mid-stream -> out_valid=0, in_ready=1, phase=0, FIFO empty immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/conv_puncturer.sv
// Puncturer for the rate-1/2 convolutional encoder output. It selects rate 1/2, 2/3 or 3/4
// and emits the surviving bits serially through a bit FIFO. Define PUNCT_CNT_EN to add drop_cnt.
module conv_puncturer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [1:0]       AB,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic [1:0]       rate,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PUNCT_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_M2 = (AW+1)'(DEPTH - 2);

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10
  } rate_e;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("conv_puncturer: DEPTH must be a power of two >= 4 and CNT_W >= 1");
  end

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr, wr_ptr, wr_b;
  logic [AW:0]      count;
  logic [1:0]       phase, rate_q, rate_sel;
  rate_e            mode;
  logic             keep_a, keep_b, last_phase;
  logic             accept, push_a, push_b, pop;
  logic [1:0]       n_push;

  assign in_ready  = (count <= FULL_M2);
  assign out_valid = (count != '0);
  assign out_bit   = mem[rd_ptr];

  always_comb begin
    // The phase-0 pair is punctured with the live rate; later pairs use the latched one.
    rate_sel   = (phase == 2'd0) ? rate : rate_q;
    mode       = RATE_1_2;
    keep_a     = 1'b1;
    keep_b     = 1'b1;
    last_phase = 1'b1;
    case (rate_sel)
      2'b01:   mode = RATE_2_3;
      2'b10:   mode = RATE_3_4;
      default: mode = RATE_1_2;
    endcase
    case (mode)
      RATE_2_3: begin
        keep_b     = (phase == 2'd0);
        last_phase = (phase == 2'd1);
      end
      RATE_3_4: begin
        keep_a     = (phase != 2'd2);
        keep_b     = (phase != 2'd1);
        last_phase = (phase == 2'd2);
      end
      default: begin
        keep_a     = 1'b1;
        keep_b     = 1'b1;
        last_phase = 1'b1;
      end
    endcase
    accept = valid_in && in_ready;
    push_a = accept && keep_a;
    push_b = accept && keep_b;
    n_push = {1'b0, push_a} + {1'b0, push_b};
    wr_b   = wr_ptr + {{(AW-1){1'b0}}, push_a};
    pop    = out_valid && out_ready;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      phase  <= '0;
      rate_q <= '0;
    end else begin
      if (push_a) mem[wr_ptr] <= AB[1];
      if (push_b) mem[wr_b]   <= AB[0];
      wr_ptr <= wr_ptr + {{(AW-2){1'b0}}, n_push};
      rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, pop};
      count  <= count + {{(AW-1){1'b0}}, n_push} - {{AW{1'b0}}, pop};
      if (accept) begin
        if (phase == 2'd0) rate_q <= rate;
        phase <= last_phase ? 2'd0 : phase + 2'd1;
      end
    end
  end

`ifdef PUNCT_CNT_EN
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (accept && !(keep_a && keep_b) && !(&drop_cnt)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_puncturer.sv
// Directed table-driven bench for conv_puncturer: puncture patterns, backpressure,
// mid-period rate change and asynchronous reset.
module tb_conv_puncturer;

  logic       Clk = 1'b0;
  logic       reset;
  logic [1:0] AB;
  logic       valid_in;
  logic       in_ready;
  logic [1:0] rate;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
`ifdef PUNCT_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  conv_puncturer #(.DEPTH(8), .CNT_W(16)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .AB        (AB),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .rate      (rate),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PUNCT_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // pairs: pair k at [2k+1:2k]; bits: j-th serial output bit at [j]
  typedef struct {
    logic [1:0]  rate;
    int          np;
    logic [11:0] pairs;
    int          nb;
    logic [7:0]  bits;
    int          drops;
  } vec_t;

  vec_t vecs [5];

  task automatic do_reset();
    reset     = 1'b1;
    valid_in  = 1'b0;
    AB        = 2'b00;
    out_ready = 1'b0;
    rate      = 2'b00;
    @(posedge Clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_bit", out_bit, 0);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int k;
    int got;
    logic acc;
    logic [7:0] obs;
    v   = vecs[i];
    k   = 0;
    got = 0;
    obs = '0;
    do_reset();
    rate      = v.rate;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < v.nb; cyc++) begin
      if (k < v.np) begin
        valid_in = 1'b1;
        AB       = v.pairs[2*k +: 2];
      end else begin
        valid_in = 1'b0;
      end
      if (cyc == 0) check($sformatf("v%0d_valid_c0", i), out_valid, 0);
      if (cyc == 1) check($sformatf("v%0d_valid_c1", i), out_valid, 1);
      if (out_valid) begin
        obs[got] = out_bit;
        got++;
      end
      acc = valid_in && in_ready;
      @(posedge Clk); #1;
      if (acc) k++;
    end
    valid_in = 1'b0;
    check($sformatf("v%0d_nbits", i), got, v.nb);
    check($sformatf("v%0d_bits", i), obs, v.bits);
    check($sformatf("v%0d_pairs", i), k, v.np);
    check($sformatf("v%0d_empty", i), out_valid, 0);
    check($sformatf("v%0d_phase", i), dut.phase, 0);
`ifdef PUNCT_CNT_EN
    check($sformatf("v%0d_drop_cnt", i), drop_cnt, v.drops);
`endif
  endtask

  initial begin
    int acc_n;
    int ones;
    int drained;
    int mc;

    vecs[0] = '{rate: 2'b00, np: 2, pairs: 12'h006, nb: 4, bits: 8'b0000_1001, drops: 0};
    vecs[1] = '{rate: 2'b01, np: 2, pairs: 12'h006, nb: 3, bits: 8'b0000_0001, drops: 1};
    vecs[2] = '{rate: 2'b10, np: 3, pairs: 12'h013, nb: 4, bits: 8'b0000_1011, drops: 2};
    vecs[3] = '{rate: 2'b11, np: 1, pairs: 12'h001, nb: 2, bits: 8'b0000_0010, drops: 0};
    vecs[4] = '{rate: 2'b10, np: 6, pairs: 12'h63F, nb: 8, bits: 8'b1100_1111, drops: 4};

    for (int i = 0; i < 5; i++) run_vec(i);

    // Backpressure: 4 pairs fill the 8-bit FIFO, then drain.
    do_reset();
    rate     = 2'b00;
    valid_in = 1'b1;
    AB       = 2'b11;
    acc_n    = 0;
    for (int c = 0; c < 10; c++) begin
      if (in_ready) acc_n++;
      @(posedge Clk); #1;
    end
    check("bp_accepts", acc_n, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_count", dut.count, 8);
    check("bp_out_valid", out_valid, 1);
    valid_in  = 1'b0;
    out_ready = 1'b1;
    ones      = 0;
    drained   = 0;
    mc        = 8;
    for (int c = 0; c < 20 && out_valid; c++) begin
      check($sformatf("bp_in_ready_c%0d", c), in_ready, (mc <= 6) ? 1 : 0);
      if (out_bit) ones++;
      drained++;
      @(posedge Clk); #1;
      mc--;
    end
    check("bp_drained", drained, 8);
    check("bp_ones", ones, 8);
    check("bp_empty", out_valid, 0);
    check("bp_ready_after", in_ready, 1);

    // Mid-period rate change, then asynchronous reset mid-stream.
    do_reset();
    rate     = 2'b01;
    valid_in = 1'b1;
    AB       = 2'b11;
    @(posedge Clk); #1;
    check("rc_phase1", dut.phase, 1);
    check("rc_count1", dut.count, 2);
    rate = 2'b10;
    @(posedge Clk); #1;
    check("rc_phase2", dut.phase, 0);
    check("rc_count2", dut.count, 3);
    AB = 2'b10;
    @(posedge Clk); #1;
    valid_in = 1'b0;
    check("rc_phase3", dut.phase, 1);
    check("rc_count3", dut.count, 5);
`ifdef PUNCT_CNT_EN
    check("rc_drop_cnt", drop_cnt, 1);
`endif
    reset = 1'b1;
    #2;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_phase", dut.phase, 0);
    check("ar_count", dut.count, 0);
    check("ar_out_bit", out_bit, 0);
`ifdef PUNCT_CNT_EN
    check("ar_drop_cnt", drop_cnt, 0);
`endif
    @(posedge Clk); #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
